// File: rtl/counter_bank_pkg.sv
// Shared types, parameter defaults and helpers for the counter bank.
package counter_bank_pkg;

  localparam int DEFAULT_WIDTH       = 4;
  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_WRAP        = 1;
  localparam int DEFAULT_RESET_VALUE = 0;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // One extra bit beyond the index range so out-of-range channels can be addressed.
  function automatic int sel_width(input int channels);
    return $clog2(channels) + 1;
  endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Registered read port of the counter bank: request/select in, valid/data out.
interface counter_bank_if #(
  parameter int CHANNELS = counter_bank_pkg::DEFAULT_CHANNELS,
  parameter int WIDTH    = counter_bank_pkg::DEFAULT_WIDTH
) ();

  localparam int SEL_W = counter_bank_pkg::sel_width(CHANNELS);

  logic             rd_req;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output rd_req,
    output rd_sel,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_sel,
    output rd_valid,
    output rd_data
  );

endinterface

// File: rtl/counter_bank_channel.sv
// One up/down counter with parallel load, wrap or saturate at the bounds,
// a registered terminal-count pulse and a sticky overflow flag.
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int WRAP        = DEFAULT_WRAP,
  parameter int RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam bit               DO_WRAP = (WRAP != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             event_hit;
  dir_e             step_dir;

  assign step_dir = dir_e'(dir);

  // Next count and event: load beats enable; a step off either bound is the event.
  always_comb begin
    count_d   = count_q;
    event_hit = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (en) begin
      if (step_dir == DIR_UP) begin
        if (count_q == CNT_MAX) begin
          event_hit = 1'b1;
          count_d   = DO_WRAP ? CNT_MIN : CNT_MAX;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == CNT_MIN) begin
          event_hit = 1'b1;
          count_d   = DO_WRAP ? CNT_MAX : CNT_MIN;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    tc_d  = event_hit;
    // Set wins over a same-cycle clear so an event is never lost.
    ovf_d = event_hit | (ovf_q & ~ovf_clr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with a registered indexed read port.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int WRAP        = DEFAULT_WRAP,
  parameter int RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc_pulse,
  output logic [CHANNELS-1:0]       ovf,
  counter_bank_if.slave             rd_bus
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    counter_channel #(
      .WIDTH       (WIDTH),
      .WRAP        (WRAP),
      .RESET_VALUE (RESET_VALUE)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en[i]),
      .dir        (dir[i]),
      .load       (load[i]),
      .load_value (load_value[i*WIDTH +: WIDTH]),
      .ovf_clr    (ovf_clr[i]),
      .count      (count[i*WIDTH +: WIDTH]),
      .tc_pulse   (tc_pulse[i]),
      .ovf        (ovf[i])
    );
  end

  // Read mux over the registered counts, so the response carries the pre-update value;
  // an out-of-range select matches no channel and returns zero.
  always_comb begin
    rd_valid_d = rd_bus.rd_req;
    rd_data_d  = '0;
    if (rd_bus.rd_req) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rd_bus.rd_sel == SEL_W'(i)) begin
          rd_data_d = count[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read response registers; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_bus.rd_valid = rd_valid_q;
  assign rd_bus.rd_data  = rd_data_q;

endmodule
